io_uart_port: RTL

Memory-mapped UART peripheral that is the responder on the processor's I/O port bus (`IO_port_ID`, `IO_write_data`, `IO_write_strobe`, `IO_read_strobe`, `IO_read_data`). It decodes port IDs, queues written bytes into a TX FIFO, serializes them as 8N1, deserializes the RX line into an RX FIFO, and returns data and status bytes on reads. It sits outside the processor core, wired directly to the core's I/O ports.

---
 rtl/io_uart_pkg.sv | 28 ++
 rtl/io_sync_fifo.sv | 55 +++++
 rtl/io_uart_port.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants and state encodings for the I/O-port UART peripheral.
package io_uart_pkg;

    localparam logic [7:0] DEFAULT_DATA_PORT   = 8'h00;
    localparam logic [7:0] DEFAULT_STATUS_PORT = 8'h01;

    localparam int STAT_RX_AVAIL  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_TX_IDLE   = 2;
    localparam int STAT_RX_OVERRUN = 3;
    localparam int STAT_FRAME_ERR = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with a combinational head; pushes when full and pops when empty are ignored.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNTW-1:0]  count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNTW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_port.sv
// 8N1 UART responder on the processor I/O port bus with TX/RX FIFOs and a status byte.
module io_uart_port
    import io_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] DATA_PORT    = DEFAULT_DATA_PORT,
    parameter logic [7:0] STATUS_PORT  = DEFAULT_STATUS_PORT
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       sticky_clear, overrun_set, frame_set;
    logic       overrun_reg, frame_err_reg;
    logic [7:0] status;

    tx_state_t  tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic       tx_line_reg, tx_line_next;

    rx_state_t  rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic       rx_meta_reg, rx_sync_reg;

    assign tx_push      = IO_write_strobe && (IO_port_ID == DATA_PORT);
    assign rx_pop       = IO_read_strobe && (IO_port_ID == DATA_PORT);
    assign sticky_clear = IO_read_strobe && (IO_port_ID == STATUS_PORT);
    assign uart_tx      = tx_line_reg;

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk100), .reset(reset), .push(tx_push), .push_data(IO_write_data),
        .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk100), .reset(reset), .push(rx_push), .push_data(rx_shift_reg),
        .pop(rx_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk100) begin
        if (!reset) begin
            tx_state_reg  <= TX_IDLE;
            tx_cnt_reg    <= '0;
            tx_bit_reg    <= '0;
            tx_shift_reg  <= '0;
            tx_line_reg   <= 1'b1;
            rx_state_reg  <= RX_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_cnt_reg    <= tx_cnt_next;
            tx_bit_reg    <= tx_bit_next;
            tx_shift_reg  <= tx_shift_next;
            tx_line_reg   <= tx_line_next;
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            rx_meta_reg   <= uart_rx;
            rx_sync_reg   <= rx_meta_reg;
            // A set event in the same cycle as a clear wins.
            if (overrun_set)       overrun_reg <= 1'b1;
            else if (sticky_clear) overrun_reg <= 1'b0;
            if (frame_set)         frame_err_reg <= 1'b1;
            else if (sticky_clear) frame_err_reg <= 1'b0;
        end
    end

    // STOP goes straight to START when another byte is queued so frames abut.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_line_next  = tx_line_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_line_next = 1'b1;
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_head;
                    tx_cnt_next   = '0;
                    tx_line_next  = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_line_next  = tx_shift_reg[0];
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 1'b1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_line_next  = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = tx_head;
                        tx_line_next  = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Samples are taken mid-bit: half a period after the falling edge, then every full period.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        overrun_set   = 1'b0;
        frame_set     = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_sync_reg) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                    else                    rx_bit_next   = rx_bit_reg + 1'b1;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_sync_reg) begin
                        rx_push       = !rx_full;
                        overrun_set   = rx_full;
                        rx_state_next = RX_IDLE;
                    end else begin
                        frame_set     = 1'b1;
                        rx_state_next = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_reg) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        status                  = 8'h00;
        status[STAT_RX_AVAIL]   = !rx_empty;
        status[STAT_TX_FULL]    = tx_full;
        status[STAT_TX_IDLE]    = tx_empty && (tx_state_reg == TX_IDLE);
        status[STAT_RX_OVERRUN] = overrun_reg;
        status[STAT_FRAME_ERR]  = frame_err_reg;
    end

    always_comb begin
        IO_read_data = 8'h00;
        if (IO_port_ID == DATA_PORT) begin
            IO_read_data = rx_empty ? 8'h00 : rx_head;
        end else if (IO_port_ID == STATUS_PORT) begin
            IO_read_data = status;
        end
    end

endmodule
